// File: rtl/alarm_setter.sv
// rtl/alarm_setter.sv - rotary-encoder alarm time setter with edit timeout
// Encoder events step an hour/minute edit; a third press commits, inactivity abandons.
module alarm_setter #(
   parameter int TIMEOUT_CYC = 1000000000,
   parameter int RST_HOUR    = 7,
   parameter int RST_MIN     = 0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] iData,
   output logic [4:0] oHour,
   output logic [5:0] oMin,
   output logic [4:0] oEditHour,
   output logic [5:0] oEditMin,
   output logic [1:0] oState,
   output logic       oCommit
);

   localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
   localparam logic [1:0] CODE_IDLE  = 2'b11;
   localparam logic [1:0] CODE_CW    = 2'b01;
   localparam logic [1:0] CODE_CCW   = 2'b10;

   typedef enum logic [1:0] {
      IDLE      = 2'b00,
      EDIT_HOUR = 2'b01,
      EDIT_MIN  = 2'b10
   } state_t;

   state_t           state;
   logic [1:0]       sync1;
   logic [1:0]       sdata;
   logic [1:0]       prev;
   logic [CNT_W-1:0] cnt;
   logic             evt;
   logic             cw;
   logic             ccw;
   logic             press;
   logic             expired;
   logic [4:0]       hour_up;
   logic [4:0]       hour_dn;
   logic [5:0]       min_up;
   logic [5:0]       min_dn;

   // A held code yields one event: only a change to a non-idle code counts.
   assign evt     = (sdata != prev) && (sdata != CODE_IDLE);
   assign cw      = evt && (sdata == CODE_CW);
   assign ccw     = evt && (sdata == CODE_CCW);
   assign press   = evt && (sdata == 2'b00);
   assign expired = (cnt == CNT_LAST);

   assign hour_up = (oEditHour == 5'd23) ? 5'd0  : oEditHour + 5'd1;
   assign hour_dn = (oEditHour == 5'd0)  ? 5'd23 : oEditHour - 5'd1;
   assign min_up  = (oEditMin == 6'd59)  ? 6'd0  : oEditMin + 6'd1;
   assign min_dn  = (oEditMin == 6'd0)   ? 6'd59 : oEditMin - 6'd1;

   assign oState = state;

   always_ff @(posedge clk) begin
      if (!rst) begin
         sync1     <= CODE_IDLE;
         sdata     <= CODE_IDLE;
         prev      <= CODE_IDLE;
         state     <= IDLE;
         cnt       <= '0;
         oHour     <= 5'(RST_HOUR);
         oMin      <= 6'(RST_MIN);
         oEditHour <= 5'(RST_HOUR);
         oEditMin  <= 6'(RST_MIN);
         oCommit   <= 1'b0;
      end else begin
         sync1   <= iData;
         sdata   <= sync1;
         prev    <= sdata;
         oCommit <= 1'b0;
         case (state)
            IDLE: begin
               cnt       <= '0;
               oEditHour <= oHour;
               oEditMin  <= oMin;
               if (press) state <= EDIT_HOUR;
            end
            EDIT_HOUR: begin
               if (evt) begin
                  cnt <= '0;
                  if (cw)       oEditHour <= hour_up;
                  else if (ccw) oEditHour <= hour_dn;
                  else          state     <= EDIT_MIN;
               end else if (expired) begin
                  state     <= IDLE;
                  cnt       <= '0;
                  oEditHour <= oHour;
                  oEditMin  <= oMin;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            EDIT_MIN: begin
               if (evt) begin
                  cnt <= '0;
                  if (cw)       oEditMin <= min_up;
                  else if (ccw) oEditMin <= min_dn;
                  else begin
                     state   <= IDLE;
                     oHour   <= oEditHour;
                     oMin    <= oEditMin;
                     oCommit <= 1'b1;
                  end
               end else if (expired) begin
                  state     <= IDLE;
                  cnt       <= '0;
                  oEditHour <= oHour;
                  oEditMin  <= oMin;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            default: begin
               state <= IDLE;
               cnt   <= '0;
            end
         endcase
      end
   end

endmodule

// File: doc/alarm_setter.md
ALARM_SETTER -- requirements
Module: alarm_setter

Interface
REQ-001 Parameter TIMEOUT_CYC, default 1000000000, meaning: clk cycles without an encoder event before an edit is abandoned (10 s at 100 MHz).
REQ-002 Parameter RST_HOUR, default 7, meaning: committed alarm hour after reset (0..23).
REQ-003 Parameter RST_MIN, default 0, meaning: committed alarm minute after reset (0..59).
REQ-004 clk  input  1  system clock, 100 MHz; the block's only clock.
REQ-005 rst  input  1  reset, synchronous, active-low; sampled on rising clk only.
REQ-006 iData  input  2  rotary encoder code: 11 idle, 01 clockwise, 10 counter-clockwise, 00 push-switch pressed.
REQ-007 oHour  output  5  committed alarm hour, 0..23.
REQ-008 oMin  output  6  committed alarm minute, 0..59.
REQ-009 oEditHour  output  5  working hour shown on the display during an edit.
REQ-010 oEditMin  output  6  working minute shown on the display during an edit.
REQ-011 oState  output  2  00 IDLE, 01 EDIT_HOUR, 10 EDIT_MIN; 11 never driven.
REQ-012 oCommit  output  1  one-cycle pulse when a new alarm time is committed.

Function
REQ-013 iData SHALL pass through a 2-flop synchronizer (both flops reset to 11) before use; the synchronized value is sdata.
REQ-014 A prev register SHALL hold the previous sdata (reset 11); an event SHALL be flagged in the cycle where sdata != prev and sdata != 11; event type is CW (01), CCW (10) or PRESS (00).
REQ-015 A held code SHALL produce exactly one event; a new event requires sdata to change again (e.g. via 11, or a direct 01->00 transition).
REQ-016 Latency SHALL be fixed: iData change at edge N -> event processed and outputs updated at edge N+3.
REQ-017 IDLE: PRESS -> EDIT_HOUR, loading oEditHour<=oHour and oEditMin<=oMin; CW/CCW ignored.
REQ-018 EDIT_HOUR: CW -> oEditHour+1 with 23 wrapping to 0; CCW -> oEditHour-1 with 0 wrapping to 23; PRESS -> EDIT_MIN.
REQ-019 EDIT_MIN: CW -> oEditMin+1 with 59 wrapping to 0; CCW -> oEditMin-1 with 0 wrapping to 59; PRESS -> IDLE, copying oEditHour/oEditMin to oHour/oMin and asserting oCommit for exactly one cycle.
REQ-020 Arithmetic SHALL be done at port width with explicit compare-and-wrap; no value outside 0..23 / 0..59 shall ever appear on any output.
REQ-021 Inactivity counter: cleared on every event and on entering EDIT_HOUR; increments every cycle in EDIT_HOUR/EDIT_MIN; width is ceil(log2(TIMEOUT_CYC+1)) bits.
REQ-022 When the counter reaches TIMEOUT_CYC-1 with no event that cycle: -> IDLE, oHour/oMin unchanged, oCommit stays 0, oEditHour/oEditMin reloaded from oHour/oMin.
REQ-023 If an event and the timeout coincide in the same cycle, the event SHALL win: it is processed normally and the counter clears.
REQ-024 In IDLE, oEditHour/oEditMin SHALL track oHour/oMin and the counter SHALL hold at 0.
REQ-025 oCommit SHALL be low in every cycle other than the single commit cycle.

Reset
REQ-026 While rst=0 at a rising clk: oHour=RST_HOUR, oMin=RST_MIN, oEditHour=RST_HOUR, oEditMin=RST_MIN, oState=00, oCommit=0, counter=0, synchronizer and prev=11.
REQ-027 Reset asserted mid-edit SHALL discard working values with no commit pulse; the first event after release is judged against prev=11.
REQ-028 Reset SHALL have no asynchronous effect; outputs change only on rising clk.

Verification
REQ-029 Reset; PRESS, 3xCW, PRESS, 2xCCW, PRESS (each code held 10 cycles, with 11 between) -> oHour=10, oMin=58, single oCommit pulse, oState=00.
REQ-030 EDIT_HOUR at 23, CW -> 0; CCW -> 23; EDIT_MIN at 59, CW -> 0; at 0, CCW -> 59.
REQ-031 iData held at 01 for 1000 cycles in EDIT_HOUR -> exactly one increment.
REQ-032 TIMEOUT_CYC=100; PRESS, CW, then idle 100 cycles -> oState=00, oHour=RST_HOUR, no oCommit, oEditHour=RST_HOUR.
REQ-033 TIMEOUT_CYC=100; CW timed to arrive in the timeout cycle -> increment applied, state stays EDIT_HOUR, counter=0.
REQ-034 rst=0 for one cycle during EDIT_MIN with working 12:34 -> all outputs return to reset values, oCommit never pulses.
